// File: rtl/seq_scan_pkg.sv
// Shared types and widths for the serial scan controller and its detector core.
package seq_scan_pkg;

   localparam int W_DEF    = 8;
   localparam int PMAX_DEF = 8;
   localparam int CW_DEF   = 16;

   // Width of a pattern length, able to hold 0..PMAX.
   localparam int LEN_W = $clog2(PMAX_DEF + 1);
   // Width of the bit index within a word, 0..W-1.
   localparam int IDX_W = $clog2(W_DEF);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   // Lengths above the history depth are treated as the full depth.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                  input int              pmax);
      return (len > LEN_W'(pmax)) ? LEN_W'(pmax) : len;
   endfunction

endpackage

// File: rtl/seq_match_core.sv
// Programmable bit-serial pattern detector: history shift register, fill
// counter, masked compare, optional non-overlap restart, registered match.
module seq_match_core
   import seq_scan_pkg::*;
#(
   parameter int PMAX = PMAX_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             bit_en,
   input  logic             bit_in,
   input  logic [PMAX-1:0]  pattern,
   input  logic [LEN_W-1:0] len,
   input  logic             overlap,
   output logic             hit,
   output logic             match
);

   logic [PMAX-1:0]  hist;
   logic [PMAX-1:0]  hist_next;
   logic [PMAX-1:0]  mask;
   logic [LEN_W-1:0] fill;
   logic [LEN_W-1:0] fill_next;

   // Next history/fill values and the compare against the masked pattern.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      hist_next = {hist[PMAX-2:0], bit_in};
      fill_next = (fill >= LEN_W'(PMAX)) ? fill : fill + LEN_W'(1);
      mask      = '0;
      for (int i = 0; i < PMAX; i++) begin
         mask[i] = (i < int'(len));
      end
      hit = bit_en && (len != '0) && (fill_next >= len) &&
            ((hist_next & mask) == (pattern & mask));
   end

   // History, fill and match register; cleared at the start of each frame.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst || clear) begin
         hist  <= '0;
         fill  <= '0;
         match <= 1'b0;
      end else begin
         match <= hit;
         if (bit_en) begin
            hist <= hist_next;
            fill <= (hit && !overlap) ? '0 : fill_next;
         end
      end
   end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-bit scan controller: accepts words over valid/ready, serializes
// them MSB-first into the detector core, counts matches and flags frame end.
module seq_scan_ctrl
   import seq_scan_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int PMAX = PMAX_DEF,
   parameter int CW   = CW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [PMAX-1:0]  cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic             in_valid,
   input  logic [W-1:0]     in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             match,
   output logic [CW-1:0]    match_count,
   output logic             done
);

   state_t           state;
   logic [W-1:0]     word_q;
   logic             last_q;
   logic [IDX_W-1:0] idx;
   logic             frame_open;

   logic [PMAX-1:0]  pat_q;
   logic [LEN_W-1:0] len_q;
   logic             ovl_q;

   logic             last_bit;
   logic             accept;
   logic             first_word;
   logic             hit;

   // Handshake and output decode from registered state.
   always_comb begin
      last_bit   = (state == SHIFT) && (idx == IDX_W'(W - 1));
      in_ready   = !rst && ((state == IDLE) || (last_bit && !last_q));
      accept     = in_valid && in_ready;
      first_word = accept && !frame_open;
      bit_valid  = (state == SHIFT);
      bit_out    = bit_valid && word_q[W-1];
      done       = (state == DONE);
   end

   // Controller FSM: word latch, bit index and frame tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         word_q     <= '0;
         last_q     <= 1'b0;
         idx        <= '0;
         frame_open <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  word_q     <= in_data;
                  last_q     <= in_last;
                  idx        <= '0;
                  frame_open <= 1'b1;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               word_q <= word_q << 1;
               if (last_bit) begin
                  if (last_q) begin
                     frame_open <= 1'b0;
                     state      <= DONE;
                  end else if (accept) begin
                     word_q <= in_data;
                     last_q <= in_last;
                     idx    <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Configuration registers, writable only outside SHIFT.
   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q <= '0;
         len_q <= '0;
         ovl_q <= 1'b1;
      end else if (cfg_we && (state != SHIFT)) begin
         pat_q <= cfg_pattern;
         len_q <= cfg_len;
         ovl_q <= cfg_overlap;
      end
   end

   // Saturating per-frame match counter, cleared when a new frame starts.
   always_ff @(posedge clk) begin
      if (rst || first_word) begin
         match_count <= '0;
      end else if (hit && (match_count != '1)) begin
         match_count <= match_count + CW'(1);
      end
   end

   seq_match_core #(
      .PMAX(PMAX)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .clear  (first_word),
      .bit_en (state == SHIFT),
      .bit_in (word_q[W-1]),
      .pattern(pat_q),
      .len    (clamp_len(len_q, PMAX)),
      .overlap(ovl_q),
      .hit    (hit),
      .match  (match)
   );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl. Cycle c is the c-th cycle after the edge
// that accepts a frame's first word; per-cycle outputs are collected into
// bit vectors indexed by c and compared with hand-derived constants.
module tb_seq_scan_ctrl;
   import seq_scan_pkg::*;

   logic             clk;
   logic             rst;
   logic             cfg_we;
   logic [7:0]       cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_overlap;
   logic             in_valid;
   logic [7:0]       in_data;
   logic             in_last;

   logic             in_ready, bit_out, bit_valid, match, done;
   logic [15:0]      match_count;
   logic             s_in_ready, s_bit_out, s_bit_valid, s_match, s_done;
   logic [1:0]       s_match_count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] bv_v, bo_v, m_v, d_v, r_v;
   logic [15:0] cnt_a [0:31];
   logic [1:0]  cnt_s [0:31];

   seq_scan_ctrl dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
      .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .bit_out(bit_out), .bit_valid(bit_valid), .match(match),
      .match_count(match_count), .done(done)
   );

   seq_scan_ctrl #(.CW(2)) dut_sat (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
      .in_data(in_data), .in_last(in_last), .in_ready(s_in_ready),
      .bit_out(s_bit_out), .bit_valid(s_bit_valid), .match(s_match),
      .match_count(s_match_count), .done(s_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input logic [7:0] pat, input int len, input logic ovl);
      cfg_we      = 1'b1;
      cfg_pattern = pat;
      cfg_len     = LEN_W'(len);
      cfg_overlap = ovl;
      tick();
      cfg_we = 1'b0;
   endtask

   // Offers one word in the current cycle; returns in cycle 1 of that word.
   task automatic send(input logic [7:0] word, input logic last);
      in_valid = 1'b1;
      in_data  = word;
      in_last  = last;
      tick();
   endtask

   // Samples n cycles; in_valid stays high through cycle 'hold', cfg_we pulses in cycle 'cfg_at'.
   task automatic record(input int n, input int hold, input int cfg_at);
      bv_v = '0; bo_v = '0; m_v = '0; d_v = '0; r_v = '0;
      for (int c = 1; c <= n; c++) begin
         if (c > hold) in_valid = 1'b0;
         cfg_we   = (c == cfg_at);
         bv_v[c]  = bit_valid;
         bo_v[c]  = bit_out;
         m_v[c]   = match;
         d_v[c]   = done;
         r_v[c]   = in_ready;
         cnt_a[c] = match_count;
         cnt_s[c] = s_match_count;
         tick();
      end
      cfg_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_cmp++;
      if ({in_ready, bit_valid, bit_out, match, done} !== 5'b0 || match_count !== 16'd0) begin
         n_bad++;
         $display("FAIL reset_outputs got rdy=%b bv=%b bo=%b m=%b d=%b cnt=%0d want all 0",
                  in_ready, bit_valid, bit_out, match, done, match_count);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_ready_release got=%b want=1", in_ready);
      end
      // Default config has length 0: the frame runs but nothing matches.
      send(8'hAA, 1'b1);
      record(10, 0, 0);
      n_cmp++;
      if (bo_v !== 32'h0000_00AA || bv_v !== 32'h0000_01FE) begin
         n_bad++;
         $display("FAIL len0_serial got bo=%h bv=%h want bo=000000aa bv=000001fe", bo_v, bv_v);
      end
      n_cmp++;
      if (m_v !== 32'h0 || cnt_a[9] !== 16'd0) begin
         n_bad++;
         $display("FAIL len0_no_match got m=%h cnt=%0d want m=0 cnt=0", m_v, cnt_a[9]);
      end
   endtask

   task automatic test_overlap();
      set_cfg(8'b101, 3, 1'b1);
      send(8'hAA, 1'b1);
      record(10, 0, 0);
      n_cmp++;
      if (m_v !== 32'h0000_0150) begin
         n_bad++;
         $display("FAIL ovl_match got=%h want=00000150", m_v);
      end
      n_cmp++;
      if (d_v !== 32'h0000_0200) begin
         n_bad++;
         $display("FAIL ovl_done got=%h want=00000200", d_v);
      end
      n_cmp++;
      if (cnt_a[9] !== 16'd3 || cnt_a[10] !== 16'd3) begin
         n_bad++;
         $display("FAIL ovl_count got=%0d/%0d want=3/3", cnt_a[9], cnt_a[10]);
      end
      n_cmp++;
      if (r_v !== 32'h0000_0400) begin
         n_bad++;
         $display("FAIL ovl_ready got=%h want=00000400", r_v);
      end
   endtask

   task automatic test_non_overlap();
      set_cfg(8'b101, 3, 1'b0);
      send(8'hAA, 1'b1);
      record(10, 0, 0);
      n_cmp++;
      if (cnt_a[1] !== 16'd0) begin
         n_bad++;
         $display("FAIL novl_count_clear got=%0d want=0", cnt_a[1]);
      end
      n_cmp++;
      if (m_v !== 32'h0000_0110) begin
         n_bad++;
         $display("FAIL novl_match got=%h want=00000110", m_v);
      end
      n_cmp++;
      if (cnt_a[9] !== 16'd2 || d_v !== 32'h0000_0200) begin
         n_bad++;
         $display("FAIL novl_count_done got cnt=%0d d=%h want cnt=2 d=00000200", cnt_a[9], d_v);
      end
   endtask

   task automatic test_back_to_back();
      set_cfg(8'b101, 3, 1'b1);
      send(8'h01, 1'b0);
      in_data = 8'h40;
      in_last = 1'b1;
      record(18, 8, 0);
      n_cmp++;
      if (bv_v !== 32'h0001_FFFE || bo_v !== 32'h0000_0500) begin
         n_bad++;
         $display("FAIL b2b_stream got bv=%h bo=%h want bv=0001fffe bo=00000500", bv_v, bo_v);
      end
      n_cmp++;
      if (m_v !== 32'h0000_0800) begin
         n_bad++;
         $display("FAIL b2b_match got=%h want=00000800", m_v);
      end
      n_cmp++;
      if (d_v !== 32'h0002_0000 || cnt_a[17] !== 16'd1) begin
         n_bad++;
         $display("FAIL b2b_done_count got d=%h cnt=%0d want d=00020000 cnt=1", d_v, cnt_a[17]);
      end
      n_cmp++;
      if (r_v !== 32'h0004_0100) begin
         n_bad++;
         $display("FAIL b2b_ready got=%h want=00040100", r_v);
      end
   endtask

   task automatic test_saturation();
      set_cfg(8'b1, 1, 1'b1);
      send(8'hFF, 1'b1);
      record(10, 0, 0);
      n_cmp++;
      if (m_v !== 32'h0000_03FC) begin
         n_bad++;
         $display("FAIL sat_pulses got=%h want=000003fc", m_v);
      end
      n_cmp++;
      if (cnt_s[3] !== 2'd2 || cnt_s[4] !== 2'd3 || cnt_s[9] !== 2'd3 || cnt_s[10] !== 2'd3) begin
         n_bad++;
         $display("FAIL sat_count got c3=%0d c4=%0d c9=%0d c10=%0d want 2/3/3/3",
                  cnt_s[3], cnt_s[4], cnt_s[9], cnt_s[10]);
      end
      n_cmp++;
      if (cnt_a[9] !== 16'd8) begin
         n_bad++;
         $display("FAIL sat_wide_count got=%0d want=8", cnt_a[9]);
      end
   endtask

   task automatic test_cfg_guard();
      set_cfg(8'b101, 3, 1'b1);
      cfg_pattern = 8'h00;
      cfg_len     = LEN_W'(1);
      cfg_overlap = 1'b1;
      send(8'hAA, 1'b1);
      record(10, 0, 3);
      n_cmp++;
      if (m_v !== 32'h0000_0150 || cnt_a[9] !== 16'd3) begin
         n_bad++;
         $display("FAIL guard_shift got m=%h cnt=%0d want m=00000150 cnt=3", m_v, cnt_a[9]);
      end
      set_cfg(8'h00, 1, 1'b1);
      send(8'hAA, 1'b1);
      record(10, 0, 0);
      n_cmp++;
      if (m_v !== 32'h0000_02A8 || cnt_a[9] !== 16'd4) begin
         n_bad++;
         $display("FAIL guard_idle got m=%h cnt=%0d want m=000002a8 cnt=4", m_v, cnt_a[9]);
      end
   endtask

   task automatic test_reset_mid_shift();
      logic saw_done;
      set_cfg(8'b101, 3, 1'b1);
      send(8'hAA, 1'b1);
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      n_cmp++;
      if ({in_ready, bit_valid, bit_out, match, done} !== 5'b0 || match_count !== 16'd0) begin
         n_bad++;
         $display("FAIL rst_mid_outputs got rdy=%b bv=%b bo=%b m=%b d=%b cnt=%0d want all 0",
                  in_ready, bit_valid, bit_out, match, done, match_count);
      end
      rst = 1'b0;
      #1;
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1 || bit_valid === 1'b1) saw_done = 1'b1;
         tick();
      end
      n_cmp++;
      if (saw_done !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_no_done got=%b want=0", saw_done);
      end
      set_cfg(8'b101, 3, 1'b1);
      send(8'hAA, 1'b1);
      record(10, 0, 0);
      n_cmp++;
      if (m_v !== 32'h0000_0150 || d_v !== 32'h0000_0200 || cnt_a[9] !== 16'd3) begin
         n_bad++;
         $display("FAIL rst_mid_refresh got m=%h d=%h cnt=%0d want m=00000150 d=00000200 cnt=3",
                  m_v, d_v, cnt_a[9]);
      end
   endtask

   initial begin
      rst         = 1'b1;
      cfg_we      = 1'b0;
      cfg_pattern = '0;
      cfg_len     = '0;
      cfg_overlap = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      in_last     = 1'b0;
      test_reset();
      test_overlap();
      test_non_overlap();
      test_back_to_back();
      test_saturation();
      test_cfg_guard();
      test_reset_mid_shift();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
